// File: rtl/down_count_syn.sv
// Loadable down-counter/timer: counts from a latched start value to zero and
// pulses tc on arrival; one-shot or auto-reload, with pause (en) and abort.
module down_count_syn #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             reload_en,
    input  logic             abort,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             busy
);

    // start is a single-cycle request with an implicit ready of (state == IDLE):
    // it is accepted only on an edge where the counter is idle and load_val is
    // nonzero; a start seen at any other time is dropped, never queued.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q, tc_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            out_q    <= '0;
            reload_q <= '0;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            out_q    <= out_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        out_d    = out_q;
        reload_d = reload_q;
        tc_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && (load_val != '0)) begin
                    out_d    = load_val;
                    reload_d = load_val;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    out_d   = '0;
                    state_d = IDLE;
                end else if (!en) begin
                    out_d = out_q;
                end else if (out_q > WIDTH'(1)) begin
                    out_d = out_q - WIDTH'(1);
                end else if (out_q == WIDTH'(1)) begin
                    out_d = '0;
                    tc_d  = 1'b1;
                    if (!reload_en) state_d = IDLE;
                end else begin
                    // Zero cycle of a reload run; reload_en may have been cleared meanwhile.
                    if (reload_en) out_d = reload_q;
                    else           state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign out  = out_q;
    assign tc   = tc_q;
    assign busy = (state_q == RUN);

endmodule

// File: tb/tb_down_count_syn.sv
// Bench for down_count_syn: cycle-by-cycle vector table on a 4-bit instance,
// plus a full-range one-shot sweep on an 8-bit instance.
module tb_down_count_syn;

    logic       clk;
    logic       reset;
    logic       start, en, reload_en, abort;
    logic [3:0] load_val;
    logic [3:0] out;
    logic       tc, busy;

    logic       start8;
    logic [7:0] load_val8;
    logic [7:0] out8;
    logic       tc8, busy8;

    int checks = 0;
    int errors = 0;

    logic [5:0] exp_q[$];
    logic [9:0] exp8_q[$];

    typedef struct {
        logic       rst, st;
        logic [3:0] lv;
        logic       en, rl, ab;
        logic [3:0] eo;
        logic       et, eb;
    } vec_t;

    vec_t vecs[$];

    down_count_syn dut (
        .clk(clk), .reset(reset), .start(start), .load_val(load_val), .en(en),
        .reload_en(reload_en), .abort(abort), .out(out), .tc(tc), .busy(busy)
    );

    down_count_syn #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .load_val(load_val8), .en(1'b1),
        .reload_en(1'b0), .abort(1'b0), .out(out8), .tc(tc8), .busy(busy8)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void add(logic rst, logic st, logic [3:0] lv, logic e, logic rl,
                                logic ab, logic [3:0] eo, logic et, logic eb);
        vec_t v;
        v.rst = rst; v.st = st; v.lv = lv; v.en = e; v.rl = rl; v.ab = ab;
        v.eo = eo; v.et = et; v.eb = eb;
        vecs.push_back(v);
    endfunction

    // driver: apply one vector on the falling edge, queue its expectation
    task automatic drive(input vec_t v);
        @(negedge clk);
        reset = v.rst; start = v.st; load_val = v.lv;
        en = v.en; reload_en = v.rl; abort = v.ab;
        exp_q.push_back({v.eo, v.et, v.eb});
    endtask

    // scoreboard: compare after the active edge
    task automatic check(input int idx);
        logic [5:0] e;
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        checks++;
        if ({out, tc, busy} !== e) begin
            errors++;
            $display("FAIL vec%0d: got out=%0d tc=%0b busy=%0b, expected out=%0d tc=%0b busy=%0b",
                     idx, out, tc, busy, e[5:2], e[1], e[0]);
        end
    endtask

    task automatic step8(input logic st, input logic [7:0] lv, input logic [7:0] eo,
                         input logic et, input logic eb);
        logic [9:0] e;
        @(negedge clk);
        start8 = st; load_val8 = lv;
        exp8_q.push_back({eo, et, eb});
        @(posedge clk);
        #1;
        e = exp8_q.pop_front();
        checks++;
        if ({out8, tc8, busy8} !== e) begin
            errors++;
            $display("FAIL w8 lv=%0d: got out=%0d tc=%0b busy=%0b, expected out=%0d tc=%0b busy=%0b",
                     eo, out8, tc8, busy8, e[9:2], e[1], e[0]);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; load_val = '0; en = 1'b0; reload_en = 1'b0; abort = 1'b0;
        start8 = 1'b0; load_val8 = '0;

        // reset for two cycles, then one-shot from 5
        add(1,0,0,1,0,0, 0,0,0);
        add(1,0,0,1,0,0, 0,0,0);
        add(0,1,5,1,0,0, 5,0,1);
        for (int i = 4; i >= 1; i--) add(0,0,0,1,0,0, 4'(i),0,1);
        add(0,0,0,1,0,0, 0,1,0);
        add(0,0,0,1,0,0, 0,0,0);
        add(0,0,0,1,0,0, 0,0,0);

        // auto-reload from 3, twelve cycles, then abort
        add(0,1,3,1,1,0, 3,0,1);
        for (int r = 0; r < 3; r++) begin
            add(0,0,0,1,1,0, 2,0,1);
            add(0,0,0,1,1,0, 1,0,1);
            add(0,0,0,1,1,0, 0,1,1);
            if (r < 2) add(0,0,0,1,1,0, 3,0,1);
        end
        add(0,0,0,1,1,1, 0,0,0);

        // pause at out=2 for three cycles: tc lands at k+7 instead of k+4
        add(0,1,4,1,0,0, 4,0,1);
        add(0,0,0,1,0,0, 3,0,1);
        add(0,0,0,1,0,0, 2,0,1);
        for (int i = 0; i < 3; i++) add(0,0,0,0,0,0, 2,0,1);
        add(0,0,0,1,0,0, 1,0,1);
        add(0,0,0,1,0,0, 0,1,0);
        add(0,0,0,1,0,0, 0,0,0);

        // abort at 6, ignored zero start, ignored start in RUN
        add(0,1,9,1,0,0, 9,0,1);
        add(0,0,0,1,0,0, 8,0,1);
        add(0,0,0,1,0,0, 7,0,1);
        add(0,0,0,1,0,0, 6,0,1);
        add(0,0,0,1,0,1, 0,0,0);
        add(0,1,0,1,0,0, 0,0,0);
        add(0,1,9,1,0,0, 9,0,1);
        add(0,1,2,1,0,0, 8,0,1);
        for (int i = 7; i >= 1; i--) add(0,0,0,1,0,0, 4'(i),0,1);
        add(0,0,0,1,0,0, 0,1,0);

        // start in RUN must not disturb the reload value
        add(0,1,3,1,1,0, 3,0,1);
        add(0,1,2,1,1,0, 2,0,1);
        add(0,0,0,1,1,0, 1,0,1);
        add(0,0,0,1,1,0, 0,1,1);
        add(0,0,0,1,1,0, 3,0,1);
        add(0,0,0,1,1,1, 0,0,0);

        // start together with abort in IDLE is accepted
        add(0,1,5,1,0,1, 5,0,1);
        add(0,0,0,1,0,1, 0,0,0);

        // reset at out=1 suppresses tc
        add(0,1,3,1,0,0, 3,0,1);
        add(0,0,0,1,0,0, 2,0,1);
        add(0,0,0,1,0,0, 1,0,1);
        add(1,0,0,1,0,0, 0,0,0);
        add(0,0,0,1,0,0, 0,0,0);

        // clear reload_en during the zero cycle: idle, no second tc
        add(0,1,2,1,1,0, 2,0,1);
        add(0,0,0,1,1,0, 1,0,1);
        add(0,0,0,1,1,0, 0,1,1);
        add(0,0,0,1,0,0, 0,0,0);
        add(0,0,0,1,0,0, 0,0,0);

        // load of 1 with a pause on the last step
        add(0,1,1,1,0,0, 1,0,1);
        add(0,0,0,0,0,0, 1,0,1);
        add(0,0,0,1,0,0, 0,1,0);
        add(0,0,0,1,0,0, 0,0,0);

        foreach (vecs[i]) begin
            drive(vecs[i]);
            check(i);
        end

        // 8-bit full range one-shot: 255 decrements, one tc, no wrap
        step8(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
        step8(1'b1, 8'd255, 8'd255, 1'b0, 1'b1);
        for (int i = 254; i >= 1; i--) step8(1'b0, 8'd0, 8'(i), 1'b0, 1'b1);
        step8(1'b0, 8'd0, 8'd0, 1'b1, 1'b0);
        step8(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
        step8(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
